// File: rtl/wb_copy_master32_if.sv
// Wishbone classic-cycle bus bundle between the copy master and a responder.
// Signal names are taken from the initiator's point of view:
//   wb_cyc_o / wb_stb_o / wb_we_o  cycle, strobe, write enable (master -> slave)
//   wb_adr_o [31:0]                 byte address                (master -> slave)
//   wb_sel_o [3:0]                  byte selects                (master -> slave)
//   wb_dat_o [31:0]                 write data                  (master -> slave)
//   wb_ack_i                        acknowledge                 (slave -> master)
//   wb_dat_i [31:0]                 read data                   (slave -> master)
interface wb_copy_master32_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_copy_master32.sv
// Wishbone classic-cycle word-copy engine. A command (source, destination,
// word count) is copied one 32-bit word at a time: read source, one idle
// cycle, write destination, one idle cycle, next word. Every access has an
// ack timeout that aborts the transfer and raises a sticky error flag.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_start         one-cycle command strobe, only accepted when idle
//   cmd_src, cmd_dst  byte addresses (bits [1:0] ignored)
//   cmd_len           number of words to copy
//   busy              transfer in progress
//   done              one-cycle completion pulse (success or abort)
//   err               sticky timeout flag, cleared by the next accepted command
//   xfer_count        words fully written in the current/last transfer
//   wb                Wishbone initiator side (wb_copy_master32_if.master)
module wb_copy_master32 #(
  parameter int len_width = 16,
  parameter int timeout   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic [31:0]          cmd_src,
  input  logic [31:0]          cmd_dst,
  input  logic [len_width-1:0] cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [len_width-1:0] xfer_count,
  wb_copy_master32_if.master   wb
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_GAP_W = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_GAP_R = 3'd4;

  // Abort fires on the edge where the counter has already seen timeout-1
  // stalled cycles, so stb is high for exactly 'timeout' cycles.
  localparam logic [7:0] TMO_LAST = 8'(timeout - 1);

  logic [2:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [len_width-1:0] cnt_q, cnt_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [len_width-1:0] len_q, len_d;

  logic                 ack;
  logic [3:0]           unused_addr_lsbs;

  // Address low bits are dropped by design; keep them visibly consumed.
  assign unused_addr_lsbs = {cmd_src[1:0], cmd_dst[1:0]};

  // Acks are only meaningful while our strobe is up; late/spurious ones drop.
  assign ack = wb.wb_ack_i & stb_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          src_d = {cmd_src[31:2], 2'b00};
          dst_d = {cmd_dst[31:2], 2'b00};
          len_d = cmd_len;
          cnt_d = '0;
          err_d = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_READ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = {cmd_src[31:2], 2'b00};
            tmo_d   = '0;
          end
        end
      end

      S_READ: begin
        if (ack) begin
          dat_d   = wb.wb_dat_i;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = S_GAP_W;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      // One idle cycle so the responder sees stb low after its ack.
      S_GAP_W: begin
        state_d = S_WRITE;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = dst_q;
        tmo_d   = '0;
      end

      S_WRITE: begin
        if (ack) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          cnt_d = cnt_q + len_width'(1);
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          len_d = len_q - len_width'(1);
          if (len_q == len_width'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP_R;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_GAP_R: begin
        state_d = S_READ;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = src_q;
        tmo_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Command registers are only consulted while busy; no reset needed.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    dst_q <= dst_d;
    len_q <= len_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign xfer_count  = cnt_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = 4'b1111;
  assign wb.wb_dat_o = dat_q;

endmodule
